// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller for the ID-stage branch comparator.
// Detects operand hazards against EX/MEM producers, stalls the front end,
// selects MEM-stage forwarding for the comparator, flushes IF/ID on a taken
// branch, and counts resolved branches, taken branches and stall cycles.
//
// state   | meaning
// S_IDLE  | no branch waiting; a branch in ID either resolves or starts a stall
// S_STALL | branch in ID is stalled on an operand; wait counts stall cycles
module branch_resolve_ctrl #(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [2:0]       id_branch_op,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             mem_reg_write,
   input  logic             mem_mem_read,
   input  logic [4:0]       mem_rd,
   input  logic             branch_taken,
   output logic             stall_pc,
   output logic             stall_if_id,
   output logic             bubble_id_ex,
   output logic             flush_if_id,
   output logic             fwd_a,
   output logic             fwd_b,
   output logic             branch_commit,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             stall_err
);

   localparam int WAIT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_STALL);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic {S_IDLE, S_STALL} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_inc;
   logic              is_br, uses_rt, rs_nz, rt_nz;
   logic              haz_rs, haz_rt, hazard, resolve;

   // ex_mem_read is implied by ex_reg_write for a load, so EX hazards key on
   // reg_write alone; a MEM-stage ALU result is forwarded instead of stalled.
   always_comb begin
      is_br   = id_valid && (id_branch_op != 3'b000);
      uses_rt = (id_branch_op == 3'b001) || (id_branch_op == 3'b010);
      rs_nz   = (id_rs != 5'd0);
      rt_nz   = (id_rt != 5'd0);
      haz_rs  = rs_nz && ((ex_reg_write && (ex_rd == id_rs)) ||
                          (mem_mem_read && (mem_rd == id_rs)));
      haz_rt  = uses_rt && rt_nz && ((ex_reg_write && (ex_rd == id_rt)) ||
                                     (mem_mem_read && (mem_rd == id_rt)));
      hazard  = is_br && (haz_rs || haz_rt);
      resolve = is_br && !hazard;

      stall_pc      = hazard;
      stall_if_id   = hazard;
      bubble_id_ex  = hazard;
      branch_commit = resolve;
      flush_if_id   = resolve && branch_taken;

      fwd_a = is_br && mem_reg_write && !mem_mem_read && rs_nz && (mem_rd == id_rs);
      fwd_b = is_br && uses_rt && mem_reg_write && !mem_mem_read && rt_nz &&
              (mem_rd == id_rt);

      wait_inc = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + WAIT_ONE;
   end

   // Branch tracking FSM, saturating counters and sticky stall error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         wait_q     <= '0;
         branch_cnt <= '0;
         taken_cnt  <= '0;
         stall_cnt  <= '0;
         stall_err  <= 1'b0;
      end else begin
         if (resolve) begin
            if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + CNT_ONE;
            if (branch_taken && (taken_cnt != CNT_MAX)) taken_cnt <= taken_cnt + CNT_ONE;
         end
         if (hazard && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;

         case (state)
            S_IDLE: begin
               if (hazard) begin
                  state  <= S_STALL;
                  wait_q <= WAIT_ONE;
                  if (MAX_STALL <= 1) stall_err <= 1'b1;
               end
            end
            S_STALL: begin
               if (hazard) begin
                  wait_q <= wait_inc;
                  if (wait_inc >= WAIT_MAX) stall_err <= 1'b1;
               end else begin
                  // resolved or killed: either way this branch instance is done
                  state  <= S_IDLE;
                  wait_q <= '0;
               end
            end
            default: begin
               state  <= S_IDLE;
               wait_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a vector table for the
// combinational decisions plus sequences for stall length, kill, reset and
// counter saturation.
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid;
   logic [2:0]  id_branch_op;
   logic [4:0]  id_rs, id_rt;
   logic        ex_reg_write, ex_mem_read;
   logic [4:0]  ex_rd;
   logic        mem_reg_write, mem_mem_read;
   logic [4:0]  mem_rd;
   logic        branch_taken;

   logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id;
   logic        fwd_a, fwd_b, branch_commit, stall_err;
   logic [15:0] branch_cnt, taken_cnt, stall_cnt;

   logic        s_stall_pc, s_stall_if_id, s_bubble_id_ex, s_flush_if_id;
   logic        s_fwd_a, s_fwd_b, s_branch_commit, s_stall_err;
   logic [2:0]  s_branch_cnt, s_taken_cnt, s_stall_cnt;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.CNT_W(16), .MAX_STALL(3)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_branch_op(id_branch_op),
      .id_rs(id_rs), .id_rt(id_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_rd(mem_rd), .branch_taken(branch_taken), .stall_pc(stall_pc),
      .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .branch_commit(branch_commit),
      .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt),
      .stall_err(stall_err)
   );

   // narrow-counter copy on the same stimulus, used for saturation
   branch_resolve_ctrl #(.CNT_W(3), .MAX_STALL(3)) dut_s (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_branch_op(id_branch_op),
      .id_rs(id_rs), .id_rt(id_rt), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_rd(mem_rd), .branch_taken(branch_taken), .stall_pc(s_stall_pc),
      .stall_if_id(s_stall_if_id), .bubble_id_ex(s_bubble_id_ex), .flush_if_id(s_flush_if_id),
      .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .branch_commit(s_branch_commit),
      .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt), .stall_cnt(s_stall_cnt),
      .stall_err(s_stall_err)
   );

   typedef struct {
      string      name;
      logic       valid;
      logic [2:0] op;
      logic [4:0] rs, rt;
      logic       ex_rw, ex_mr;
      logic [4:0] ex_rd;
      logic       mem_rw, mem_mr;
      logic [4:0] mem_rd;
      logic       taken;
      logic       e_stall, e_flush, e_fa, e_fb, e_commit;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic erw, input logic emr, input logic [4:0] erd,
                      input logic mrw, input logic mmr, input logic [4:0] mrd, input logic tk);
      id_valid = v; id_branch_op = op; id_rs = rs; id_rt = rt;
      ex_reg_write = erw; ex_mem_read = emr; ex_rd = erd;
      mem_reg_write = mrw; mem_mem_read = mmr; mem_rd = mrd; branch_taken = tk;
   endtask

   task automatic idle_in();
      drv(1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   // bgtz r5 with lw r5 in EX: hazard
   task automatic haz_in();
      drv(1'b1, 3'd4, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   // bgtz r5 with no producers: resolves
   task automatic res_in(input logic tk);
      drv(1'b1, 3'd4, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, tk);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   task automatic chk_cnt(input string nm, input int b, input int t, input int s, input logic e);
      chk({nm, " branch_cnt"}, 32'(branch_cnt), 32'(b));
      chk({nm, " taken_cnt"},  32'(taken_cnt),  32'(t));
      chk({nm, " stall_cnt"},  32'(stall_cnt),  32'(s));
      chk({nm, " stall_err"},  32'(stall_err),  32'(e));
   endtask

   initial begin
      int mb, mt, ms;
      //            name         v  op    rs     rt     erw  emr  erd    mrw  mmr  mrd    tk   st fl fa fb cm
      vecs[0]  = '{"idle",       0, 3'd0, 5'd0,  5'd0,  0,   0,   5'd0,  0,   0,   5'd0,  0,   0, 0, 0, 0, 0};
      vecs[1]  = '{"beq_taken",  1, 3'd1, 5'd1,  5'd2,  0,   0,   5'd0,  0,   0,   5'd0,  1,   0, 1, 0, 0, 1};
      vecs[2]  = '{"bne_ex_alu", 1, 3'd2, 5'd3,  5'd4,  1,   0,   5'd3,  0,   0,   5'd0,  0,   1, 0, 0, 0, 0};
      vecs[3]  = '{"bne_fwd_a",  1, 3'd2, 5'd3,  5'd4,  0,   0,   5'd0,  1,   0,   5'd3,  0,   0, 0, 1, 0, 1};
      vecs[4]  = '{"bgtz_ex_lw", 1, 3'd4, 5'd5,  5'd0,  1,   1,   5'd5,  0,   0,   5'd0,  0,   1, 0, 0, 0, 0};
      vecs[5]  = '{"bgtz_mem_lw",1, 3'd4, 5'd5,  5'd0,  0,   0,   5'd0,  1,   1,   5'd5,  0,   1, 0, 0, 0, 0};
      vecs[6]  = '{"bgtz_res",   1, 3'd4, 5'd5,  5'd0,  0,   0,   5'd0,  0,   0,   5'd0,  1,   0, 1, 0, 0, 1};
      vecs[7]  = '{"bgez_rt_ex", 1, 3'd5, 5'd6,  5'd7,  1,   0,   5'd7,  0,   0,   5'd0,  0,   0, 0, 0, 0, 1};
      vecs[8]  = '{"beq_r0",     1, 3'd1, 5'd0,  5'd8,  1,   0,   5'd0,  1,   0,   5'd0,  1,   0, 1, 0, 0, 1};
      vecs[9]  = '{"invalid",    0, 3'd1, 5'd3,  5'd4,  1,   0,   5'd3,  1,   0,   5'd4,  1,   0, 0, 0, 0, 0};
      vecs[10] = '{"beq_fwd_b",  1, 3'd1, 5'd9,  5'd10, 0,   0,   5'd0,  1,   0,   5'd10, 0,   0, 0, 0, 1, 1};
      vecs[11] = '{"blez_no_rt", 1, 3'd3, 5'd11, 5'd12, 0,   0,   5'd0,  1,   0,   5'd12, 0,   0, 0, 0, 0, 1};
      vecs[12] = '{"beq_mem_lw", 1, 3'd1, 5'd13, 5'd14, 0,   0,   5'd0,  1,   1,   5'd13, 0,   1, 0, 0, 0, 0};
      vecs[13] = '{"haz_igntk",  1, 3'd1, 5'd13, 5'd14, 0,   0,   5'd0,  1,   1,   5'd13, 1,   1, 0, 0, 0, 0};
      vecs[14] = '{"idle2",      0, 3'd0, 5'd0,  5'd0,  0,   0,   5'd0,  0,   0,   5'd0,  0,   0, 0, 0, 0, 0};
      vecs[15] = '{"beq_rt_lw",  1, 3'd1, 5'd1,  5'd2,  1,   1,   5'd2,  0,   0,   5'd0,  0,   1, 0, 0, 0, 0};

      reset_n = 1'b0;
      idle_in();
      #1;
      chk_cnt("reset", 0, 0, 0, 1'b0);
      chk("reset stall_pc", 32'(stall_pc), 32'd0);
      chk("reset commit", 32'(branch_commit), 32'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;

      // vector table
      mb = 0; mt = 0; ms = 0;
      for (int i = 0; i < 16; i++) begin
         drv(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ex_rw, vecs[i].ex_mr,
             vecs[i].ex_rd, vecs[i].mem_rw, vecs[i].mem_mr, vecs[i].mem_rd, vecs[i].taken);
         #1;
         chk({vecs[i].name, " stall_pc"},     32'(stall_pc),      32'(vecs[i].e_stall));
         chk({vecs[i].name, " stall_if_id"},  32'(stall_if_id),   32'(vecs[i].e_stall));
         chk({vecs[i].name, " bubble_id_ex"}, 32'(bubble_id_ex),  32'(vecs[i].e_stall));
         chk({vecs[i].name, " flush_if_id"},  32'(flush_if_id),   32'(vecs[i].e_flush));
         chk({vecs[i].name, " fwd_a"},        32'(fwd_a),         32'(vecs[i].e_fa));
         chk({vecs[i].name, " fwd_b"},        32'(fwd_b),         32'(vecs[i].e_fb));
         chk({vecs[i].name, " commit"},       32'(branch_commit), 32'(vecs[i].e_commit));
         if (vecs[i].e_commit) mb++;
         if (vecs[i].e_commit && vecs[i].taken) mt++;
         if (vecs[i].e_stall) ms++;
         cyc();
      end
      idle_in();
      chk_cnt("table", mb, mt, ms, 1'b0);

      // kill mid-stall returns to idle: a later 2-cycle stall must not chain
      do_reset();
      haz_in(); cyc();
      haz_in(); cyc();
      idle_in(); cyc();
      haz_in(); cyc();
      haz_in(); cyc();
      idle_in();
      chk_cnt("kill", 0, 0, 4, 1'b0);
      cyc();

      // hazard held MAX_STALL cycles sets the sticky error
      haz_in(); cyc();
      haz_in(); cyc();
      chk("err after 2 stalls", 32'(stall_err), 32'd0);
      haz_in(); cyc();
      chk("err after 3 stalls", 32'(stall_err), 32'd1);
      res_in(1'b1);
      #1;
      chk("maxstall commit", 32'(branch_commit), 32'd1);
      chk("maxstall flush", 32'(flush_if_id), 32'd1);
      cyc();
      idle_in(); cyc();
      chk_cnt("maxstall", 1, 1, 7, 1'b1);

      // async reset mid-stall with counters at 5/3/4
      do_reset();
      res_in(1'b1); cyc();
      res_in(1'b1); cyc();
      res_in(1'b1); cyc();
      res_in(1'b0); cyc();
      haz_in(); cyc();
      haz_in(); cyc();
      res_in(1'b0); cyc();
      haz_in(); cyc();
      haz_in(); cyc();
      chk_cnt("pre-reset", 5, 3, 4, 1'b0);
      reset_n = 1'b0;
      #1;
      chk_cnt("async reset", 0, 0, 0, 1'b0);
      chk("reset stall follows input", 32'(stall_pc), 32'd1);
      idle_in();
      #1;
      chk("reset idle stall_pc", 32'(stall_pc), 32'd0);
      chk("reset idle flush", 32'(flush_if_id), 32'd0);
      chk("reset idle fwd_a", 32'(fwd_a), 32'd0);
      reset_n = 1'b1;
      haz_in(); cyc();
      haz_in(); cyc();
      idle_in(); cyc();
      chk_cnt("post-reset", 0, 0, 2, 1'b0);

      // saturation on the 3-bit instance
      do_reset();
      for (int i = 0; i < 9; i++) begin
         haz_in(); cyc();
         res_in(1'b1); cyc();
      end
      idle_in(); cyc();
      chk("sat branch_cnt", 32'(s_branch_cnt), 32'd7);
      chk("sat taken_cnt",  32'(s_taken_cnt),  32'd7);
      chk("sat stall_cnt",  32'(s_stall_cnt),  32'd7);
      chk_cnt("wide after 9", 9, 9, 9, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
